// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the RV32IM 5-stage pipeline: merges branch
// redirects, multi-cycle MUL/DIV occupancy of EX and load-use hazards into one set of controls.
module pipeline_stall_controller #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 34,
  parameter int CNT_W   = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  ID_RS1,
  input  logic [4:0]  ID_RS2,
  input  logic        ID_USES_RS1,
  input  logic        ID_USES_RS2,
  input  logic        EX_MEMREAD,
  input  logic [4:0]  EX_RD,
  input  logic        EX_MDU_VALID,
  input  logic        EX_MDU_IS_DIV,
  input  logic        BRANCH_TAKEN,
  input  logic        CLR_STATS,
  output logic        PC_WE,
  output logic        IFID_WE,
  output logic        IDEX_WE,
  output logic        IDEX_BUBBLE,
  output logic        EXMEM_BUBBLE,
  output logic        IFID_FLUSH,
  output logic        MDU_DONE,
  output logic        MDU_BUSY,
  output logic [15:0] STALL_COUNT
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  // The first EX cycle is the IDLE cycle that detects the op, so the countdown starts at LAT-2.
  localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'((DIV_LAT > 1) ? (DIV_LAT - 2) : 0);
  localparam bit               MUL_MULTI = (MUL_LAT > 1);
  localparam bit               DIV_MULTI = (DIV_LAT > 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [15:0]       stall_count_r;

  logic              load_use_s;
  logic              mdu_multi_s;
  logic [CNT_W-1:0]  mdu_load_s;

  logic              pc_we_s;
  logic              ifid_we_s;
  logic              idex_we_s;
  logic              idex_bubble_s;
  logic              exmem_bubble_s;
  logic              ifid_flush_s;
  logic              mdu_done_s;
  logic              mdu_busy_s;

  function automatic logic src_hit(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
    return uses && (rs == rd);
  endfunction

  assign load_use_s  = EX_MEMREAD && (EX_RD != 5'd0) &&
                       (src_hit(ID_USES_RS1, ID_RS1, EX_RD) || src_hit(ID_USES_RS2, ID_RS2, EX_RD));
  assign mdu_multi_s = EX_MDU_IS_DIV ? DIV_MULTI : MUL_MULTI;
  assign mdu_load_s  = EX_MDU_IS_DIV ? DIV_LOAD : MUL_LOAD;

  // Prioritised control decode and next-state selection.
  always_comb begin
    pc_we_s        = 1'b1;
    ifid_we_s      = 1'b1;
    idex_we_s      = 1'b1;
    idex_bubble_s  = 1'b0;
    exmem_bubble_s = 1'b0;
    ifid_flush_s   = 1'b0;
    mdu_done_s     = 1'b0;
    mdu_busy_s     = 1'b0;
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    if (RESET) begin
      pc_we_s     = 1'b0;
      ifid_we_s   = 1'b0;
      idex_we_s   = 1'b0;
      state_nxt_s = IDLE;
      cnt_nxt_s   = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (BRANCH_TAKEN) begin
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
          end else if (EX_MDU_VALID) begin
            if (mdu_multi_s) begin
              pc_we_s        = 1'b0;
              ifid_we_s      = 1'b0;
              idex_we_s      = 1'b0;
              exmem_bubble_s = 1'b1;
              state_nxt_s    = MDU_WAIT;
              cnt_nxt_s      = mdu_load_s;
            end else begin
              mdu_done_s = 1'b1;
            end
          end else if (load_use_s) begin
            pc_we_s       = 1'b0;
            ifid_we_s     = 1'b0;
            idex_bubble_s = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        MDU_WAIT: begin
          mdu_busy_s = 1'b1;
          if (cnt_r != {CNT_W{1'b0}}) begin
            pc_we_s        = 1'b0;
            ifid_we_s      = 1'b0;
            idex_we_s      = 1'b0;
            exmem_bubble_s = 1'b1;
            cnt_nxt_s      = cnt_r - CNT_W'(1);
          end else begin
            mdu_done_s  = 1'b1;
            state_nxt_s = IDLE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // FSM state, MDU countdown and saturating stall statistics.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      stall_count_r <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (CLR_STATS) begin
        stall_count_r <= 16'h0000;
      end else if (!pc_we_s && (stall_count_r != 16'hFFFF)) begin
        stall_count_r <= stall_count_r + 16'd1;
      end else begin
        stall_count_r <= stall_count_r;
      end
    end
  end

  assign PC_WE        = pc_we_s;
  assign IFID_WE      = ifid_we_s;
  assign IDEX_WE      = idex_we_s;
  assign IDEX_BUBBLE  = idex_bubble_s;
  assign EXMEM_BUBBLE = exmem_bubble_s;
  assign IFID_FLUSH   = ifid_flush_s;
  assign MDU_DONE     = mdu_done_s;
  assign MDU_BUSY     = mdu_busy_s;
  assign STALL_COUNT  = stall_count_r;

endmodule
